// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit : LIFO stack behind the core's PUSH/POP/CALL/RET strobes.
//
// PUSH stores a data word taken from BUS_in. CALL stores the return address
// stack_IP+1. POP and RET present the top entry combinationally, so the core
// captures it on the same edge that pops.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : push-when-full / pop-when-empty are blocked and set sticky
//               stack_ovf / stack_udf flags (cleared by stack_clr_err)
//   undefined : the pointer and the memory index wrap modulo DEPTH, and the
//               error flags are tied to 0
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   stack_read_data   push strobe (PUSH or CALL)
//   stack_write_data  pop strobe (POP or RET)
//   stack_sel_ip      1 = address frame (CALL/RET), 0 = data frame
//   stack_IP          inout: sampled on CALL, driven with top on RET
//   BUS_in            data word to push
//   BUS_out           top word during a data pop, Z otherwise
//   stack_count       occupied entries 0..DEPTH
//   stack_full/empty  count == DEPTH / count == 0
//   stack_ovf/udf     sticky overflow / underflow
//   stack_clr_err     clears the sticky flags
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stack_read_data,
    input  logic             stack_write_data,
    input  logic             stack_sel_ip,
    inout  wire  [WIDTH-1:0] stack_IP,
    input  logic [WIDTH-1:0] BUS_in,
    output wire  [WIDTH-1:0] BUS_out,
    output logic [PTR_W:0]   stack_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_ovf,
    output logic             stack_udf,
    input  logic             stack_clr_err
);

    localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LP_ONE   = (PTR_W+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_sp;

    logic             w_push;
    logic             w_pop;
    logic             w_both;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_top_idx;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_push_val;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W:0]   w_sp_nxt;
    logic             w_ovf_set;
    logic             w_udf_set;

    assign w_push  = stack_read_data && !stack_write_data;
    assign w_pop   = stack_write_data && !stack_read_data;
    assign w_both  = stack_read_data && stack_write_data;
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == LP_DEPTH);

    // Low pointer bits minus one wraps naturally: sp=0 -> DEPTH-1 and
    // sp=DEPTH -> DEPTH-1, which is exactly the top slot in both cases.
    assign w_top_idx = r_sp[PTR_W-1:0] - PTR_W'(1);

`ifdef STACK_GUARD_EN
    assign w_top = w_empty ? '0 : r_mem[w_top_idx];
`else
    assign w_top = r_mem[w_top_idx];
`endif

    // CALL stores the address of the instruction after the call.
    assign w_push_val = stack_sel_ip ? (stack_IP + WIDTH'(1)) : BUS_in;

    assign stack_IP = (stack_write_data && stack_sel_ip)  ? w_top : 'z;
    assign BUS_out  = (stack_write_data && !stack_sel_ip) ? w_top : 'z;

    always_comb begin
        w_sp_nxt  = r_sp;
        w_we      = 1'b0;
        w_waddr   = r_sp[PTR_W-1:0];
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        if (w_push) begin
`ifdef STACK_GUARD_EN
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_we     = 1'b1;
                w_sp_nxt = r_sp + LP_ONE;
            end
`else
            w_we     = 1'b1;
            w_sp_nxt = w_full ? LP_ONE : (r_sp + LP_ONE);
`endif
        end else if (w_pop) begin
`ifdef STACK_GUARD_EN
            if (w_empty) begin
                w_udf_set = 1'b1;
            end else begin
                w_sp_nxt = r_sp - LP_ONE;
            end
`else
            w_sp_nxt = w_empty ? (LP_DEPTH - LP_ONE) : (r_sp - LP_ONE);
`endif
        end else if (w_both) begin
            w_we = 1'b1;
            if (w_empty) begin
                // Underflowing pop followed by an ordinary push into slot 0.
`ifdef STACK_GUARD_EN
                w_udf_set = 1'b1;
`endif
                w_waddr  = '0;
                w_sp_nxt = LP_ONE;
            end else begin
                // Replace the top in place; the pop output still shows the old top.
                w_waddr = w_top_idx;
            end
        end
    end

    // Memory is data only and is never cleared by reset.
    always_ff @(posedge CLK) begin
        if (w_we && !RESET) begin
            r_mem[w_waddr] <= w_push_val;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sp <= '0;
        end else begin
            r_sp <= w_sp_nxt;
        end
    end

`ifdef STACK_GUARD_EN
    logic r_ovf;
    logic r_udf;

    // A new error in the clearing cycle keeps its flag set.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !stack_clr_err) || w_ovf_set;
            r_udf <= (r_udf && !stack_clr_err) || w_udf_set;
        end
    end

    assign stack_ovf = r_ovf;
    assign stack_udf = r_udf;
`else
    logic w_unused;
    assign w_unused  = ^{stack_clr_err, w_ovf_set, w_udf_set};
    assign stack_ovf = 1'b0;
    assign stack_udf = 1'b0;
`endif

    assign stack_count = r_sp;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit : self-checking bench for stack_unit (DEPTH=16, WIDTH=16).
// Directed scenarios followed by randomized traffic, compared against an
// array-based reference model. Honours STACK_GUARD_EN the same way the DUT does.
// ---------------------------------------------------------------------------
module tb_stack_unit;

    localparam int W = 16;
    localparam int D = 16;

    logic          CLK;
    logic          RESET;
    logic          stack_read_data;
    logic          stack_write_data;
    logic          stack_sel_ip;
    wire  [W-1:0]  stack_IP;
    logic [W-1:0]  BUS_in;
    wire  [W-1:0]  BUS_out;
    logic [4:0]    stack_count;
    logic          stack_full;
    logic          stack_empty;
    logic          stack_ovf;
    logic          stack_udf;
    logic          stack_clr_err;

    logic [W-1:0]  tb_ip;
    logic          tb_ip_oe;

    assign stack_IP = tb_ip_oe ? tb_ip : 'z;

    stack_unit #(.WIDTH(W), .DEPTH(D), .PTR_W(4)) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .stack_read_data  (stack_read_data),
        .stack_write_data (stack_write_data),
        .stack_sel_ip     (stack_sel_ip),
        .stack_IP         (stack_IP),
        .BUS_in           (BUS_in),
        .BUS_out          (BUS_out),
        .stack_count      (stack_count),
        .stack_full       (stack_full),
        .stack_empty      (stack_empty),
        .stack_ovf        (stack_ovf),
        .stack_udf        (stack_udf),
        .stack_clr_err    (stack_clr_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: plain array plus an integer occupancy count.
    logic [W-1:0] m_mem [D];
    int           m_sp  = 0;
    bit           m_ovf = 0;
    bit           m_udf = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_top();
`ifdef STACK_GUARD_EN
        if (m_sp == 0) return '0;
        return m_mem[m_sp-1];
`else
        return m_mem[(m_sp + D - 1) % D];
`endif
    endfunction

    task automatic m_update(input bit rst, input bit rd, input bit wr,
                            input logic [W-1:0] val, input bit clr);
        bit ovf_new = 0;
        bit udf_new = 0;
        if (rst) begin
            m_sp  = 0;
            m_ovf = 0;
            m_udf = 0;
            return;
        end
        if (rd && !wr) begin
`ifdef STACK_GUARD_EN
            if (m_sp == D) ovf_new = 1;
            else begin m_mem[m_sp] = val; m_sp++; end
`else
            m_mem[m_sp % D] = val;
            m_sp = (m_sp == D) ? 1 : m_sp + 1;
`endif
        end else if (wr && !rd) begin
`ifdef STACK_GUARD_EN
            if (m_sp == 0) udf_new = 1;
            else m_sp--;
`else
            m_sp = (m_sp == 0) ? D - 1 : m_sp - 1;
`endif
        end else if (rd && wr) begin
            if (m_sp == 0) begin
                udf_new = 1;
                m_mem[0] = val;
                m_sp = 1;
            end else begin
                m_mem[m_sp-1] = val;
            end
        end
`ifdef STACK_GUARD_EN
        m_ovf = (m_ovf && !clr) || ovf_new;
        m_udf = (m_udf && !clr) || udf_new;
`else
        m_ovf = 0;
        m_udf = 0;
        if (clr || ovf_new || udf_new) m_ovf = 0;
`endif
    endtask

    // One clock cycle: drive, check combinational pop data, clock, check state.
    // Called just after a rising edge; returns just after the next one.
    task automatic step(input bit rst, input bit rd, input bit wr, input bit sel,
                        input logic [W-1:0] bus, input logic [W-1:0] ip,
                        input bit clr, output logic [W-1:0] popv);
        logic [W-1:0] val;
        RESET            = rst;
        stack_read_data  = rd;
        stack_write_data = wr;
        stack_sel_ip     = sel;
        BUS_in           = bus;
        tb_ip            = ip;
        tb_ip_oe         = rd && sel && !wr;
        stack_clr_err    = clr;
        #3;
        popv = sel ? stack_IP : BUS_out;
        if (wr) check(sel ? "ret_ip" : "pop_bus", popv, m_top());
        val = sel ? ip + 16'd1 : bus;
        m_update(rst, rd, wr, val, clr);
        @(posedge CLK);
        #1;
        RESET            = 1'b0;
        stack_read_data  = 1'b0;
        stack_write_data = 1'b0;
        stack_sel_ip     = 1'b0;
        tb_ip_oe         = 1'b0;
        stack_clr_err    = 1'b0;
        check("count", stack_count, m_sp);
        check("full",  stack_full,  m_sp == D);
        check("empty", stack_empty, m_sp == 0);
        check("ovf",   stack_ovf,   m_ovf);
        check("udf",   stack_udf,   m_udf);
    endtask

    initial begin : main
        logic [W-1:0] pv;
        RESET = 0; stack_read_data = 0; stack_write_data = 0; stack_sel_ip = 0;
        BUS_in = '0; tb_ip = '0; tb_ip_oe = 0; stack_clr_err = 0;
        #1;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, pv);
        check("rst_count", stack_count, 0);
        check("rst_empty", stack_empty, 1);

        // Give every memory slot a known value, then drain.
        for (int i = 0; i < D; i++) step(0, 1, 0, 0, W'($urandom), 0, 0, pv);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, 0, 0, pv);

        // Data round trip
        step(0, 1, 0, 0, 16'h1234, 0, 0, pv); check("rt_cnt1", stack_count, 1);
        step(0, 1, 0, 0, 16'hABCD, 0, 0, pv); check("rt_cnt2", stack_count, 2);
        step(0, 0, 1, 0, 0, 0, 0, pv);        check("rt_pop1", pv, 16'hABCD);
        check("rt_cnt3", stack_count, 1);
        step(0, 0, 1, 0, 0, 0, 0, pv);        check("rt_pop2", pv, 16'h1234);
        check("rt_cnt4", stack_count, 0);

        // Call / return, including return-address wrap
        step(0, 1, 0, 1, 0, 16'h0040, 0, pv);
        step(0, 0, 1, 1, 0, 0, 0, pv);        check("ret_0041", pv, 16'h0041);
        step(0, 1, 0, 1, 0, 16'hFFFF, 0, pv);
        step(0, 1, 0, 0, 16'h5555, 0, 0, pv);
        step(0, 0, 1, 0, 0, 0, 0, pv);        check("pop_5555", pv, 16'h5555);
        step(0, 0, 1, 1, 0, 0, 0, pv);        check("ret_wrap", pv, 16'h0000);

        // 17 pushes at DEPTH 16
        for (int i = 0; i < 17; i++) step(0, 1, 0, 0, W'(16'h0101 * (i + 1)), 0, 0, pv);
`ifdef STACK_GUARD_EN
        check("ovf_cnt", stack_count, 16);
        check("ovf_flag", stack_ovf, 1);
        step(0, 0, 0, 0, 0, 0, 1, pv);
        check("ovf_clr", stack_ovf, 0);
        step(0, 0, 1, 0, 0, 0, 0, pv);        check("ovf_top", pv, 16'h1010);
`else
        check("wrap_cnt", stack_count, 1);
        step(0, 0, 1, 0, 0, 0, 0, pv);        check("wrap_top", pv, 16'h1111);
`endif
        for (int i = 0; i < D && m_sp > 0; i++) step(0, 0, 1, 0, 0, 0, 0, pv);

        // Pop when empty
        step(0, 0, 1, 0, 0, 0, 0, pv);
`ifdef STACK_GUARD_EN
        check("udf_data", pv, 16'h0000);
        check("udf_cnt", stack_count, 0);
        check("udf_flag", stack_udf, 1);
`else
        check("udf_wrap_data", pv, 16'h1010);
        check("udf_wrap_cnt", stack_count, 15);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit rd, wr, sel, rst, clr;
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            sel = $urandom_range(0, 1);
            if (rd && wr) sel = 0;
            rst = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 7) == 0);
            step(rst, rd, wr, sel, W'($urandom), W'($urandom), clr, pv);
        end

        // Reset mid-stream together with a push strobe
        step(1, 0, 0, 0, 0, 0, 0, pv);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, W'($urandom), 0, 0, pv);
        step(1, 1, 0, 0, 16'h7777, 0, 0, pv);
        check("rst_mid_cnt", stack_count, 0);
        check("rst_mid_empty", stack_empty, 1);
        check("rst_mid_ovf", stack_ovf, 0);
        check("rst_mid_udf", stack_udf, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

LIFO stack serving the core's PUSH/POP/CALL/RET commands. It sits directly downstream of the core's stack strobes and `stack_IP` bus. On PUSH it stores a data word from the data bus, and on CALL it stores the return address. On POP it returns the top data word, and on RET it returns the stored address. Top-of-stack is presented combinationally, so the core's IP register or the destination register captures it on the same clock edge that pops.

## Interface
Parameters:
- `WIDTH`, 16, data/address word width (matches `NUMBER_WIDTH_DATA_WIRE`)
- `DEPTH`, 16, number of entries, power of two
- `PTR_W`, 4, log2(`DEPTH`)

Ports:
- `CLK`  in  1  clock, all state changes on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `stack_read_data`  in  1  push strobe (PUSH or CALL)
- `stack_write_data`  in  1  pop strobe (POP or RET)
- `stack_sel_ip`  in  1  1 = address frame (CALL/RET), 0 = data frame (PUSH/POP)
- `stack_IP`  inout  `WIDTH`  sampled on CALL; driven with top on RET; Z otherwise
- `BUS_in`  in  `WIDTH`  data word to push
- `BUS_out`  out  `WIDTH`  top word during data pop; Z otherwise
- `stack_count`  out  `PTR_W+1`  occupied entries, 0..`DEPTH`
- `stack_full`, `stack_empty`  out  1  count == `DEPTH` / count == 0
- `stack_ovf`, `stack_udf`  out  1  sticky overflow / underflow flags
- `stack_clr_err`  in  1  clears sticky flags

## Operation
- State: `mem[0..DEPTH-1]`, stack pointer `sp` (`PTR_W+1` bits), which equals `stack_count`. Top entry is `mem[sp-1]`.
- Push (`stack_read_data`=1, `stack_write_data`=0):
  - writes `mem[sp]`, then sp+1.
  - Stored value is `BUS_in` when `stack_sel_ip`=0.
  - Stored value is `stack_IP`+1 (mod 2^`WIDTH`, the return address) when `stack_sel_ip`=1.
- Pop (`stack_write_data`=1, `stack_read_data`=0):
  - `mem[sp-1]` is driven combinationally on `stack_IP` when `stack_sel_ip`=1, or on `BUS_out` when 0.
  - sp-1 at the edge.
- Simultaneous push and pop:
  - Non-empty: top entry is replaced with the push value; sp unchanged; pop output still shows the old top.
  - Empty: handled as an underflowing pop plus a normal push; sp becomes 1.
- Full/empty (with guard, see Configuration):
  - Push when full: no write, sp unchanged, `stack_ovf`←1.
  - Pop when empty: outputs drive all-zero, sp unchanged, `stack_udf`←1.
- `stack_clr_err`=1 clears both sticky flags at the edge. A new error in the same cycle wins, and its flag stays 1.
- Frame type is not tracked. Popping a data word with RET is the programmer's error and is not detected.

## Timing
- Reset values: sp=0, `stack_count`=0, `stack_empty`=1, `stack_full`=0, `stack_ovf`=0, `stack_udf`=0, `BUS_out`=Z, `stack_IP` not driven.
- RESET dominates all strobes in the same cycle. Memory contents are not cleared.
- Push latency: 1 cycle. The entry is readable as top in the cycle after the push edge.
- Pop data is valid in the same cycle the strobe is high, purely combinational from sp and mem. No extra wait state; the consumer captures it at the strobe edge.
- Tri-state enables:
  - `stack_IP` is driven only while `stack_write_data`&`stack_sel_ip`.
  - `BUS_out` is driven only while `stack_write_data`&!`stack_sel_ip`.
- Flags and count are registered and reflect the state after the last edge.
- Back-to-back strobes are permitted every cycle.

## Configuration
- `STACK_GUARD_EN` defined:
  - Full/empty blocking as described above.
  - Sticky `stack_ovf`/`stack_udf` behave as specified.
- `STACK_GUARD_EN` undefined:
  - No blocking. `mem` index wraps modulo `DEPTH`.
  - Push when full overwrites `mem[0]`; sp wraps from `DEPTH` to 1.
  - Pop when empty reads `mem[DEPTH-1]`; sp wraps to `DEPTH-1`.
  - `stack_ovf`/`stack_udf` are tied to 0; `stack_clr_err` is ignored.
  - `stack_full`/`stack_empty` still decode sp.

## Test plan
- Data round trip: push 0x1234, then push 0xABCD, then pop twice → `BUS_out` shows 0xABCD then 0x1234 in the pop cycles; count goes 1,2,1,0.
- Call/ret: CALL with `stack_IP`=0x0040, then RET with `stack_sel_ip`=1 → `stack_IP` driven 0x0041 during the RET cycle.
- Return-address wrap: CALL with `stack_IP`=0xFFFF → later RET drives 0x0000.
- Guarded overflow (macro defined): 17 pushes at DEPTH=16 → count stays 16, `stack_ovf`=1 after the 17th edge, `mem[15]` intact. Then `stack_clr_err` → flag 0.
- Underflow and wrap:
  - Macro defined: pop when empty → `BUS_out`=0x0000, `stack_udf`=1, count 0.
  - Macro undefined: same pop reads `mem[15]`, count becomes 15.
- Reset mid-stream: 3 pushes, then RESET asserted together with a push strobe → count=0, `stack_empty`=1, flags 0 on the next cycle.
